// File: rtl/pattern_det_param.sv
// -----------------------------------------------------------------------------
// pattern_det_param
//
// Bit-serial sequence detector with a parametrised pattern. Every accepted bit
// (in_valid=1) is shifted into a short history; when enough bits have been
// accepted and the history plus the current bit equals PATTERN, a detection
// is flagged and a saturating counter is advanced. The pattern is matched by
// plain shift/compare, so any LEN/PATTERN pair elaborates without a
// per-pattern state machine.
//
// Parameters
//   LEN      pattern length in bits, 2..32
//   PATTERN  pattern bits; the MSB is the first bit received
//   OVERLAP  1 = overlapping detection, 0 = no bit of a detection is reused
//   MOORE    0 = match is combinational (same cycle as the last bit)
//            1 = match is registered (cycle after the last bit)
//   CNT_W    width of the detection counter
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      din is accepted only when in_valid=1
//   din        in   1      serial data bit
//   cnt_clr    in   1      synchronous clear of match_cnt (wins over a detection)
//   match      out  1      one pulse per detection
//   match_cnt  out  CNT_W  detections since reset/clear, saturating
//   cnt_sat    out  1      match_cnt is at its all-ones maximum
// -----------------------------------------------------------------------------
module pattern_det_param #(
    parameter int             LEN     = 5,
    parameter logic [LEN-1:0] PATTERN = 5'b00101,
    parameter bit             OVERLAP = 1'b1,
    parameter bit             MOORE   = 1'b0,
    parameter int             CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             din,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    // fill counts 0..LEN-1; LEN >= 2 keeps this at least one bit wide.
    localparam int                FILL_W   = $clog2(LEN);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(LEN - 1);

    // Only the newest LEN-1 bits are ever compared again (the current din
    // supplies the last pattern bit), so the oldest history bit is not kept.
    logic [LEN-2:0]    hist;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_next;
    logic [LEN-1:0]    window;
    logic              full;
    logic              det;

    // Candidate pattern: stored history followed by the bit on the wire now.
    assign window = {hist, din};
    assign full   = (fill == FILL_MAX);

    // rst is folded in so the combinational match stays low during reset.
    assign det = in_valid & ~rst & full & (window == PATTERN);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        fill_next = fill;
        if (det && !OVERLAP) begin
            // Non-overlapping: the bits of this detection cannot be reused.
            fill_next = '0;
        end else if (!full) begin
            fill_next = fill + FILL_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
        end else if (in_valid) begin
            hist <= window[LEN-2:0];
            fill <= fill_next;
        end
    end

    // Saturating detection counter; a clear has priority over a detection.
    assign cnt_sat = &match_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (det && !cnt_sat) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end

    // Output timing: registered in Moore mode, so the pulse lands in the cycle
    // after the last bit even if in_valid has dropped by then. det is low on
    // invalid cycles, so the register clears itself after one cycle.
    generate
        if (MOORE) begin : g_moore
            logic match_r;

            always_ff @(posedge clk) begin
                if (rst) begin
                    match_r <= 1'b0;
                end else begin
                    match_r <= det;
                end
            end

            assign match = match_r;
        end else begin : g_mealy
            assign match = det;
        end
    endgenerate

endmodule

// File: tb/tb_pattern_det_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_pattern_det_param
//
// Several detector configurations share one input stream. A behavioural model
// keeps, per configuration, the list of bits accepted since the last reset (or
// last non-overlapping detection) and detects by comparing the tail of that
// list with the pattern. For every driven cycle the expected outputs are
// pushed into a per-instance queue; a monitor on the falling edge pops and
// compares. Directed sequences add explicit constant checks.
// -----------------------------------------------------------------------------
module tb_pattern_det_param;

    localparam int          NI = 7;
    localparam int          LEN_A [NI] = '{5, 4, 4, 5, 5, 2, 32};
    localparam logic [31:0] PAT_A [NI] = '{32'h05, 32'hA, 32'hA, 32'h05,
                                           32'h05, 32'h3, 32'hDEADBEEF};
    localparam bit          OV_A  [NI] = '{1, 1, 0, 1, 1, 0, 1};
    localparam bit          MO_A  [NI] = '{0, 0, 0, 1, 0, 1, 0};
    localparam int          CW_A  [NI] = '{16, 16, 16, 16, 2, 3, 4};

    typedef struct {
        logic        m;
        logic [31:0] c;
        logic        s;
    } exp_t;

    logic clk;
    logic rst;
    logic in_valid;
    logic din;
    logic cnt_clr;

    logic [NI-1:0] match_o;
    logic [NI-1:0] sat_o;
    logic [31:0]   cnt_o [NI];

    int tests_run = 0;
    int tests_failed = 0;

    // Scoreboard queues and model state.
    exp_t        sb   [NI][$];
    bit          hq   [NI][$];
    bit          mr   [NI];
    int unsigned mcnt [NI];

    generate
        for (genvar k = 0; k < NI; k++) begin : g_dut
            localparam int             L = LEN_A[k];
            localparam int             W = CW_A[k];
            localparam logic [L-1:0]   P = PAT_A[k][L-1:0];
            logic [W-1:0] cnt_w;
            logic         m_w;
            logic         s_w;

            pattern_det_param #(
                .LEN     (L),
                .PATTERN (P),
                .OVERLAP (OV_A[k]),
                .MOORE   (MO_A[k]),
                .CNT_W   (W)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .in_valid  (in_valid),
                .din       (din),
                .cnt_clr   (cnt_clr),
                .match     (m_w),
                .match_cnt (cnt_w),
                .cnt_sat   (s_w)
            );

            assign match_o[k] = m_w;
            assign sat_o[k]   = s_w;
            assign cnt_o[k]   = 32'(cnt_w);
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one call per driven cycle, after inputs are applied.
    task automatic model_step();
        for (int k = 0; k < NI; k++) begin
            bit          det;
            logic [31:0] w;
            int          n;
            int unsigned mx;
            exp_t        e;

            det = 1'b0;
            n   = hq[k].size();
            if (!rst && in_valid && n >= LEN_A[k] - 1) begin
                w = '0;
                for (int i = n - (LEN_A[k] - 1); i < n; i++) w = {w[30:0], hq[k][i]};
                w   = {w[30:0], din};
                det = (w == PAT_A[k]);
            end
            mx  = (32'd1 << CW_A[k]) - 32'd1;
            e.m = MO_A[k] ? mr[k] : det;
            e.c = mcnt[k];
            e.s = (mcnt[k] == mx);
            sb[k].push_back(e);

            if (rst) begin
                hq[k].delete();
                mr[k]   = 1'b0;
                mcnt[k] = 0;
            end else begin
                mr[k] = det;
                if (in_valid) begin
                    hq[k].push_back(din);
                    if (det && !OV_A[k]) hq[k].delete();
                    if (hq[k].size() > 32) void'(hq[k].pop_front());
                end
                if (cnt_clr) mcnt[k] = 0;
                else if (det && mcnt[k] != mx) mcnt[k]++;
            end
        end
    endtask

    // One clock cycle of stimulus, applied just after the rising edge.
    task automatic cycle(input bit v, input bit d, input bit c, input bit r);
        @(posedge clk);
        #1;
        in_valid = v;
        din      = d;
        cnt_clr  = c;
        rst      = r;
        model_step();
    endtask

    task automatic feed(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) cycle(1'b1, bits[i], 1'b0, 1'b0);
    endtask

    // Monitor: compare whatever the DUTs present against the queued response.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (sb[k].size() > 0) begin
                exp_t e;
                e = sb[k].pop_front();
                check($sformatf("u%0d.match", k), {31'b0, match_o[k]}, {31'b0, e.m});
                check($sformatf("u%0d.match_cnt", k), cnt_o[k], e.c);
                check($sformatf("u%0d.cnt_sat", k), {31'b0, sat_o[k]}, {31'b0, e.s});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq5;
        rst      = 1'b1;
        in_valid = 1'b0;
        din      = 1'b0;
        cnt_clr  = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state.
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        @(negedge clk);
        check("reset_cnt_u0", cnt_o[0], 0);
        check("reset_match_u3", {31'b0, match_o[3]}, 0);

        // T1: 00101 on the default configuration.
        seq5 = 8'b00101;
        for (int i = 0; i < 5; i++) begin
            cycle(1, seq5[4-i], 0, 0);
            @(negedge clk);
            check("t1_match_u0", {31'b0, match_o[0]}, {31'b0, (i == 4)});
        end
        cycle(0, 0, 0, 0);
        @(negedge clk);
        check("t1_cnt_u0", cnt_o[0], 1);

        // T2/T3: 101010 with pattern 1010, overlapping and not.
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            cycle(1, (i % 2 == 0), 0, 0);
            @(negedge clk);
            check("t2_match_u1", {31'b0, match_o[1]}, {31'b0, (i == 3 || i == 5)});
            check("t3_match_u2", {31'b0, match_o[2]}, {31'b0, (i == 3)});
        end
        cycle(0, 0, 0, 0);
        @(negedge clk);
        check("t2_cnt_u1", cnt_o[1], 2);
        check("t3_cnt_u2", cnt_o[2], 1);

        // T4: Moore with invalid gaps inside the pattern.
        cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        @(negedge clk);
        check("t4_mealy_u0", {31'b0, match_o[0]}, 1);
        check("t4_moore_early_u3", {31'b0, match_o[3]}, 0);
        cycle(0, 1, 0, 0);
        @(negedge clk);
        check("t4_moore_u3", {31'b0, match_o[3]}, 1);
        check("t4_cnt_u3", cnt_o[3], 1);
        cycle(0, 0, 0, 0);
        @(negedge clk);
        check("t4_moore_drop_u3", {31'b0, match_o[3]}, 0);

        // T5: reset mid-pattern discards progress.
        cycle(0, 0, 0, 1);
        feed(32'b001, 3);
        cycle(0, 0, 0, 1);
        feed(32'b01, 2);
        @(negedge clk);
        check("t5_nomatch_u0", {31'b0, match_o[0]}, 0);
        feed(32'b00101, 5);
        @(negedge clk);
        check("t5_match_u0", {31'b0, match_o[0]}, 1);
        cycle(0, 0, 0, 0);
        @(negedge clk);
        check("t5_cnt_u0", cnt_o[0], 1);

        // T6: 2-bit counter saturates; clear wins over a coincident detection.
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) feed(32'b00101, 5);
        cycle(0, 0, 0, 0);
        @(negedge clk);
        check("t6_cnt_sat_u4", cnt_o[4], 3);
        check("t6_sat_u4", {31'b0, sat_o[4]}, 1);
        feed(32'b0010, 4);
        cycle(1, 1, 1, 0);
        @(negedge clk);
        check("t6_clr_det_u4", {31'b0, match_o[4]}, 1);
        cycle(0, 0, 0, 0);
        @(negedge clk);
        check("t6_clr_cnt_u4", cnt_o[4], 0);
        check("t6_clr_sat_u4", {31'b0, sat_o[4]}, 0);

        // LEN=2 non-overlap Moore: 1111 -> detections on bits 2 and 4.
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 0, 0);
            @(negedge clk);
            check("len2_match_u5", {31'b0, match_o[5]}, {31'b0, (i == 2)});
        end
        cycle(0, 0, 0, 0);
        @(negedge clk);
        check("len2_last_u5", {31'b0, match_o[5]}, 1);
        check("len2_cnt_u5", cnt_o[5], 2);

        // LEN=32 pattern.
        cycle(0, 0, 0, 1);
        feed(32'hDEADBEEF, 32);
        @(negedge clk);
        check("len32_match_u6", {31'b0, match_o[6]}, 1);
        cycle(0, 0, 0, 0);
        @(negedge clk);
        check("len32_cnt_u6", cnt_o[6], 1);

        // Randomised traffic, with occasional injected 32-bit patterns.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                for (int i = 31; i >= 0; i--) begin
                    logic [31:0] pat;
                    pat = 32'hDEADBEEF;
                    while ($urandom_range(0, 3) == 0) cycle(0, 1'($urandom), 0, 0);
                    cycle(1, pat[i], 0, 0);
                end
            end else begin
                cycle($urandom_range(0, 3) != 0, 1'($urandom),
                      $urandom_range(0, 99) == 0, $urandom_range(0, 299) == 0);
            end
        end
        cycle(0, 0, 0, 0);

        @(negedge clk);
        #1;
        for (int k = 0; k < NI; k++) check($sformatf("u%0d.sb_drain", k), sb[k].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
